// File: rtl/hazard_stall_unit.sv
//============================================================================
//  Module      : hazard_stall_unit
//  Description : ID-stage interlock. Stalls PC and IF/ID and bubbles ID/EX
//                for load-use, branch-compare-in-ID and MULT/DIV busy.
//                Owns the HI/LO busy FSM.
//                Optional macro HAZARD_STATS_EN adds stall statistics
//                counters (stat_lu_cnt, stat_md_cnt).
//  Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module hazard_stall_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_flush,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_func,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_write_reg,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_write_reg,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        bubble_idex,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stat_lu_cnt,
    output logic [31:0] stat_md_cnt
`endif
);

    localparam logic [5:0] c_MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] c_DIV_LOAD  = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    md_state_t  r_state;
    md_state_t  w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;

    logic w_use_rs;
    logic w_use_rt;
    logic w_is_branch;
    logic w_is_mfhilo;
    logic w_is_md_op;
    logic w_id_live;
    logic w_match_ex;
    logic w_match_mem;
    logic w_lu;
    logic w_br_ex;
    logic w_br_ld;
    logic w_md;
    logic w_reg_cause;
    logic w_stall;
    logic w_issue;
    logic [5:0] w_md_load;

    // Decode which source registers the ID instruction reads
    always_comb begin
        w_use_rs    = 1'b0;
        w_use_rt    = 1'b0;
        w_is_branch = 1'b0;
        w_is_mfhilo = 1'b0;
        w_is_md_op  = 1'b0;
        if (id_opcode == 6'h00) begin
            w_is_md_op = (id_func[5:2] == 4'b0110);
            case (id_func)
                6'h00, 6'h02, 6'h03: w_use_rt = 1'b1;
                6'h08:               w_use_rs = 1'b1;
                6'h10, 6'h12:        w_is_mfhilo = 1'b1;
                default: begin
                    w_use_rs = 1'b1;
                    w_use_rt = 1'b1;
                end
            endcase
        end else begin
            case (id_opcode)
                6'h02, 6'h03, 6'h0F: ;
                6'h04, 6'h05: begin
                    w_use_rs    = 1'b1;
                    w_use_rt    = 1'b1;
                    w_is_branch = 1'b1;
                end
                default: begin
                    w_use_rs = 1'b1;
                    w_use_rt = (id_opcode[5:2] == 4'b1010);
                end
            endcase
        end
    end

    // Register dependency matching and stall cause combination
    always_comb begin
        w_id_live   = id_valid && !id_flush;
        w_match_ex  = (ex_write_reg != 5'd0) &&
                      ((w_use_rs && (id_rs == ex_write_reg)) ||
                       (w_use_rt && (id_rt == ex_write_reg)));
        w_match_mem = (mem_write_reg != 5'd0) &&
                      ((w_use_rs && (id_rs == mem_write_reg)) ||
                       (w_use_rt && (id_rt == mem_write_reg)));
        w_lu        = ex_mem_read && w_match_ex;
        w_br_ex     = w_is_branch && ex_reg_write && !ex_mem_read && w_match_ex;
        w_br_ld     = w_is_branch && mem_mem_read && w_match_mem;
        w_md        = (w_is_mfhilo || w_is_md_op) && md_busy && !md_done;
        w_reg_cause = w_id_live && (w_lu || w_br_ex || w_br_ld);
        w_stall     = w_id_live && (w_lu || w_br_ex || w_br_ld || w_md);
        // A stalled MULT/DIV is not issued; it retries once ID advances
        w_issue     = w_id_live && !w_stall && w_is_md_op;
        w_md_load   = id_func[1] ? c_DIV_LOAD : c_MULT_LOAD;
    end

    assign stall_pc    = w_stall;
    assign stall_ifid  = w_stall;
    assign bubble_idex = w_stall;
    assign md_busy     = (r_state != ST_IDLE);
    assign md_done     = (r_state == ST_DONE);

    // MULT/DIV occupancy state and countdown register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MULT/DIV next state: issue loads the count, RUN counts down to DONE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = w_md_load;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - 6'd1;
                if (r_cnt <= 6'd1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_issue) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = w_md_load;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stat_lu;
    logic [31:0] r_stat_md;

    // Count register-dependency stalls and stalls caused only by MULT/DIV busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_lu <= 32'd0;
            r_stat_md <= 32'd0;
        end else begin
            if (w_reg_cause) begin
                r_stat_lu <= r_stat_lu + 32'd1;
            end
            if (w_stall && !w_reg_cause) begin
                r_stat_md <= r_stat_md + 32'd1;
            end
        end
    end

    assign stat_lu_cnt = r_stat_lu;
    assign stat_md_cnt = r_stat_md;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
//============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Directed self-checking bench for hazard_stall_unit.
//  Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_hazard_stall_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_flush;
    logic [5:0]  id_opcode;
    logic [5:0]  id_func;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_write_reg;
    logic        mem_mem_read;
    logic [4:0]  mem_write_reg;
    logic        stall_pc;
    logic        stall_ifid;
    logic        bubble_idex;
    logic        md_busy;
    logic        md_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_lu_cnt;
    logic [31:0] stat_md_cnt;
`endif

    int n_pass;
    int n_total;

    hazard_stall_unit #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_flush      (id_flush),
        .id_opcode     (id_opcode),
        .id_func       (id_func),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_write_reg  (ex_write_reg),
        .mem_mem_read  (mem_mem_read),
        .mem_write_reg (mem_write_reg),
        .stall_pc      (stall_pc),
        .stall_ifid    (stall_ifid),
        .bubble_idex   (bubble_idex),
        .md_busy       (md_busy),
        .md_done       (md_done)
`ifdef HAZARD_STATS_EN
        ,
        .stat_lu_cnt   (stat_lu_cnt),
        .stat_md_cnt   (stat_md_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_id(input logic v, input logic f, input logic [5:0] op,
                            input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt);
        id_valid  = v;
        id_flush  = f;
        id_opcode = op;
        id_func   = fn;
        id_rs     = rs;
        id_rt     = rt;
    endtask

    task automatic drive_ex(input logic rw, input logic mr, input logic [4:0] wr);
        ex_reg_write = rw;
        ex_mem_read  = mr;
        ex_write_reg = wr;
    endtask

    task automatic drive_mem(input logic mr, input logic [4:0] wr);
        mem_mem_read  = mr;
        mem_write_reg = wr;
    endtask

    task automatic idle_all();
        drive_id(1'b0, 1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        drive_ex(1'b0, 1'b0, 5'd0);
        drive_mem(1'b0, 5'd0);
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        #3;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        #2;
        n_total++;
        if ({stall_pc, stall_ifid, bubble_idex} !== 3'b000) $display("FAIL reset_stall: got %b expected 000", {stall_pc, stall_ifid, bubble_idex});
        else n_pass++;
        n_total++;
        if ({md_busy, md_done} !== 2'b00) $display("FAIL reset_md: got busy/done %b expected 00", {md_busy, md_done});
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        // LW $8 in EX, ADD $9,$8,$10 in ID
        drive_id(1'b1, 1'b0, 6'h00, 6'h20, 5'd8, 5'd10);
        drive_ex(1'b1, 1'b1, 5'd8);
        drive_mem(1'b0, 5'd0);
        settle();
        n_total++;
        if ({stall_pc, stall_ifid, bubble_idex} !== 3'b111) $display("FAIL lu_stall: got %b expected 111", {stall_pc, stall_ifid, bubble_idex});
        else n_pass++;
        step();
        drive_ex(1'b0, 1'b0, 5'd0);
        drive_mem(1'b1, 5'd8);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL lu_release: got %b expected 0", stall_pc);
        else n_pass++;
        step();
        idle_all();
    endtask

    task automatic test_no_hazard();
        // load to $0 never matches
        drive_id(1'b1, 1'b0, 6'h00, 6'h20, 5'd0, 5'd10);
        drive_ex(1'b1, 1'b1, 5'd0);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL lu_zero_reg: got %b expected 0", stall_pc);
        else n_pass++;
        // SLL reads rt only; rs=8 is ignored
        drive_id(1'b1, 1'b0, 6'h00, 6'h00, 5'd8, 5'd11);
        drive_ex(1'b1, 1'b1, 5'd8);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL sll_rs_ignored: got %b expected 0", stall_pc);
        else n_pass++;
        // SW $8 reads rt as store data
        drive_id(1'b1, 1'b0, 6'h2B, 6'h00, 5'd3, 5'd8);
        settle();
        n_total++;
        if (stall_pc !== 1'b1) $display("FAIL store_rt: got %b expected 1", stall_pc);
        else n_pass++;
        // LUI reads nothing
        drive_id(1'b1, 1'b0, 6'h0F, 6'h00, 5'd8, 5'd8);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL lui_none: got %b expected 0", stall_pc);
        else n_pass++;
        // ADDI reads rs only; rt is its destination
        drive_id(1'b1, 1'b0, 6'h08, 6'h00, 5'd3, 5'd8);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL addi_rt_ignored: got %b expected 0", stall_pc);
        else n_pass++;
        // invalid and flushed ID suppress the stall
        drive_id(1'b0, 1'b0, 6'h00, 6'h20, 5'd8, 5'd10);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL invalid_id: got %b expected 0", stall_pc);
        else n_pass++;
        drive_id(1'b1, 1'b1, 6'h00, 6'h20, 5'd8, 5'd10);
        settle();
        n_total++;
        if (bubble_idex !== 1'b0) $display("FAIL flushed_id: got %b expected 0", bubble_idex);
        else n_pass++;
        // ALU producer in EX feeding a non-branch is forwarded
        drive_id(1'b1, 1'b0, 6'h00, 6'h20, 5'd8, 5'd10);
        drive_ex(1'b1, 1'b0, 5'd8);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL alu_forward: got %b expected 0", stall_pc);
        else n_pass++;
        step();
        idle_all();
    endtask

    task automatic test_branch_load();
        // LW $4 in EX, BEQ $4,$5 in ID
        drive_id(1'b1, 1'b0, 6'h04, 6'h00, 5'd4, 5'd5);
        drive_ex(1'b1, 1'b1, 5'd4);
        settle();
        n_total++;
        if (stall_pc !== 1'b1) $display("FAIL br_ld_cycle1: got %b expected 1", stall_pc);
        else n_pass++;
        step();
        drive_ex(1'b0, 1'b0, 5'd0);
        drive_mem(1'b1, 5'd4);
        settle();
        n_total++;
        if (stall_ifid !== 1'b1) $display("FAIL br_ld_cycle2: got %b expected 1", stall_ifid);
        else n_pass++;
        step();
        drive_mem(1'b0, 5'd0);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL br_ld_cycle3: got %b expected 0", stall_pc);
        else n_pass++;
        step();
        // BNE $6,$7 with ALU producer of $7 in EX
        drive_id(1'b1, 1'b0, 6'h05, 6'h00, 5'd6, 5'd7);
        drive_ex(1'b1, 1'b0, 5'd7);
        settle();
        n_total++;
        if (stall_pc !== 1'b1) $display("FAIL br_ex: got %b expected 1", stall_pc);
        else n_pass++;
        step();
        drive_ex(1'b0, 1'b0, 5'd0);
        drive_mem(1'b0, 5'd7);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL br_ex_release: got %b expected 0", stall_pc);
        else n_pass++;
        step();
        idle_all();
    endtask

    // Issue an op then hold MFLO in ID; expect `stalls` stall cycles then md_done
    task automatic run_md_then_mflo(input logic [5:0] fn, input int stalls, input string tag);
        int n_stall_err;
        n_stall_err = 0;
        drive_id(1'b1, 1'b0, 6'h00, fn, 5'd2, 5'd3);
        settle();
        n_total++;
        if ({stall_pc, md_busy} !== 2'b00) $display("FAIL %s_issue: got stall/busy %b expected 00", tag, {stall_pc, md_busy});
        else n_pass++;
        step();
        drive_id(1'b1, 1'b0, 6'h00, 6'h12, 5'd0, 5'd0);
        for (int i = 0; i < stalls; i++) begin
            settle();
            if ({stall_pc, md_busy, md_done} !== 3'b110) begin
                n_stall_err++;
                $display("FAIL %s_run_cycle%0d: got stall/busy/done %b expected 110", tag, i + 1, {stall_pc, md_busy, md_done});
            end
            step();
        end
        n_total++;
        if (n_stall_err != 0) $display("FAIL %s_stall_cycles: got %0d bad cycles expected 0", tag, n_stall_err);
        else n_pass++;
        settle();
        n_total++;
        if ({stall_pc, md_busy, md_done} !== 3'b011) $display("FAIL %s_done: got stall/busy/done %b expected 011", tag, {stall_pc, md_busy, md_done});
        else n_pass++;
        step();
        idle_all();
        settle();
        n_total++;
        if ({md_busy, md_done} !== 2'b00) $display("FAIL %s_idle: got busy/done %b expected 00", tag, {md_busy, md_done});
        else n_pass++;
        step();
    endtask

    task automatic test_mult();
        run_md_then_mflo(6'h18, 3, "mult");
    endtask

    task automatic test_div();
        run_md_then_mflo(6'h1A, 31, "div");
    endtask

    task automatic test_reset_mid_div();
        logic seen_done;
        drive_id(1'b1, 1'b0, 6'h00, 6'h1B, 5'd2, 5'd3);
        step();
        idle_all();
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({md_busy, md_done} !== 2'b00) $display("FAIL rst_mid_run: got busy/done %b expected 00", {md_busy, md_done});
        else n_pass++;
        #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            settle();
            if (md_done === 1'b1 || md_busy === 1'b1) seen_done = 1'b1;
        end
        n_total++;
        if (seen_done !== 1'b0) $display("FAIL rst_no_done: got activity %b expected 0", seen_done);
        else n_pass++;
        drive_id(1'b1, 1'b0, 6'h00, 6'h10, 5'd0, 5'd0);
        settle();
        n_total++;
        if (stall_pc !== 1'b0) $display("FAIL rst_mfhi: got %b expected 0", stall_pc);
        else n_pass++;
        step();
        idle_all();
    endtask

    task automatic test_flush_issue();
        drive_id(1'b1, 1'b1, 6'h00, 6'h18, 5'd2, 5'd3);
        step();
        idle_all();
        settle();
        n_total++;
        if (md_busy !== 1'b0) $display("FAIL flush_no_issue: got busy %b expected 0", md_busy);
        else n_pass++;
        step();
        settle();
        n_total++;
        if (md_busy !== 1'b0) $display("FAIL flush_still_idle: got busy %b expected 0", md_busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        // MULT issues, a second MULT waits in ID, then issues during DONE
        drive_id(1'b1, 1'b0, 6'h00, 6'h18, 5'd2, 5'd3);
        step();
        for (int i = 0; i < 3; i++) begin
            settle();
            n_total++;
            if ({stall_pc, md_busy} !== 2'b11) $display("FAIL b2b_hold%0d: got stall/busy %b expected 11", i + 1, {stall_pc, md_busy});
            else n_pass++;
            step();
        end
        settle();
        n_total++;
        if ({stall_pc, md_done} !== 2'b01) $display("FAIL b2b_done1: got stall/done %b expected 01", {stall_pc, md_done});
        else n_pass++;
        step();
        drive_id(1'b1, 1'b0, 6'h00, 6'h12, 5'd0, 5'd0);
        settle();
        n_total++;
        if ({stall_pc, md_busy, md_done} !== 3'b110) $display("FAIL b2b_rerun: got stall/busy/done %b expected 110", {stall_pc, md_busy, md_done});
        else n_pass++;
        step();
        step();
        step();
        settle();
        n_total++;
        if ({stall_pc, md_done} !== 2'b01) $display("FAIL b2b_done2: got stall/done %b expected 01", {stall_pc, md_done});
        else n_pass++;
        step();
        idle_all();
        step();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        do_reset();
        drive_id(1'b1, 1'b0, 6'h00, 6'h20, 5'd8, 5'd10);
        drive_ex(1'b1, 1'b1, 5'd8);
        step();
        drive_ex(1'b0, 1'b0, 5'd0);
        drive_mem(1'b1, 5'd8);
        step();
        idle_all();
        settle();
        n_total++;
        if (stat_lu_cnt !== 32'd1) $display("FAIL stat_lu: got %0d expected 1", stat_lu_cnt);
        else n_pass++;
        n_total++;
        if (stat_md_cnt !== 32'd0) $display("FAIL stat_md: got %0d expected 0", stat_md_cnt);
        else n_pass++;
        step();
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_load();
        test_mult();
        test_div();
        test_reset_mid_div();
        test_flush_issue();
        do_reset();
        test_back_to_back();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
